// File: rtl/water_alarm_driver.sv
// Water level alarm driver: qualifies the raw level code on a slow tick,
// then drives a thermometer LED bar, a hysteretic drain pump and a mutable blinking buzzer.
module water_alarm_driver #(
  parameter int TICK_DIV   = 5_000_000,
  parameter int QUAL_TICKS = 3,
  parameter int SLOW_TICKS = 4,
  parameter int FAST_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic       ack,
  output logic [2:0] level_q,
  output logic [7:0] led,
  output logic       buzzer,
  output logic       pump,
  output logic       alarm_active
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int QW   = $clog2(QUAL_TICKS + 1);
  localparam int BMAX = (SLOW_TICKS > FAST_TICKS) ? SLOW_TICKS : FAST_TICKS;
  localparam int BW   = $clog2(BMAX + 1);

  typedef enum logic [1:0] {NORMAL, ALERT, MUTED} fsm_t;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [2:0]    cand_q, cand_d;
  logic [QW-1:0] stab_q, stab_d;
  logic [2:0]    level_d;
  logic          level_chg;
  logic [7:0]    led_q, led_d;
  logic          pump_q, pump_d;
  logic          alarm_q, alarm_d;
  logic          buzz_q, buzz_d;
  fsm_t          fsm_q, fsm_d;
  logic [2:0]    mute_lvl_q, mute_lvl_d;
  logic [BW-1:0] blink_q, blink_d, half;
  logic          off_q, off_d;
  logic          entry;

  // Free-running tick prescaler
  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  // Any change in the sampled code restarts qualification; acceptance needs
  // QUAL_TICKS consecutive ticks of the same candidate.
  always_comb begin
    cand_d  = cand_q;
    stab_d  = stab_q;
    level_d = level_q;
    if (state != cand_q) begin
      cand_d = state;
      stab_d = '0;
    end else if (tick) begin
      if (stab_q == QW'(QUAL_TICKS - 1)) level_d = cand_q;
      else                               stab_d  = stab_q + QW'(1);
    end
  end

  assign level_chg = (level_d != level_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q  <= '0;
      stab_q  <= '0;
      level_q <= '0;
    end else begin
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < 8; i++) led_d[i] = (3'(i) <= level_q);
    pump_d = pump_q;
    if (level_q >= 3'd5)      pump_d = 1'b1;
    else if (level_q <= 3'd2) pump_d = 1'b0;
    alarm_d = level_q[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= '0;
      pump_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      led_q   <= led_d;
      pump_q  <= pump_d;
      alarm_q <= alarm_d;
    end
  end

  // Mute FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= NORMAL;
      mute_lvl_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      mute_lvl_q <= mute_lvl_d;
    end
  end

  // Mute FSM: next state; a drop below 4 wins over a simultaneous ack
  always_comb begin
    fsm_d      = fsm_q;
    mute_lvl_d = mute_lvl_q;
    case (fsm_q)
      NORMAL: if (level_q[2]) fsm_d = ALERT;
      ALERT: begin
        if (!level_q[2]) fsm_d = NORMAL;
        else if (ack) begin
          fsm_d      = MUTED;
          mute_lvl_d = level_q;
        end
      end
      MUTED: begin
        if (!level_q[2])              fsm_d = NORMAL;
        else if (level_q > mute_lvl_q) fsm_d = ALERT;
      end
      default: fsm_d = NORMAL;
    endcase
  end

  // Blink phase; off_q == 0 is the audible half so a cleared phase starts on
  always_comb begin
    entry   = (fsm_d == ALERT) && (fsm_q != ALERT);
    half    = (level_q == 3'd6) ? BW'(FAST_TICKS - 1) : BW'(SLOW_TICKS - 1);
    blink_d = blink_q;
    off_d   = off_q;
    if (level_chg || entry) begin
      blink_d = '0;
      off_d   = 1'b0;
    end else if (fsm_q == ALERT && tick) begin
      if (blink_q >= half) begin
        blink_d = '0;
        off_d   = ~off_q;
      end else begin
        blink_d = blink_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q <= '0;
      off_q   <= 1'b0;
    end else begin
      blink_q <= blink_d;
      off_q   <= off_d;
    end
  end

  // Mute FSM: output; decoded from next state so mute and entry act on the same edge
  always_comb begin
    buzz_d = (fsm_d == ALERT) && ((level_q == 3'd7) || !off_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) buzz_q <= 1'b0;
    else     buzz_q <= buzz_d;
  end

  assign led          = led_q;
  assign pump         = pump_q;
  assign alarm_active = alarm_q;
  assign buzzer       = buzz_q;

endmodule

// File: tb/tb_water_alarm_driver.sv
// Directed bench for water_alarm_driver with a level-change scoreboard.
module tb_water_alarm_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ack = 1'b0;
  logic [2:0] state = 3'd0;
  logic [2:0] level_q;
  logic [7:0] led;
  logic       buzzer, pump, alarm_active;

  typedef struct packed {
    logic [2:0] lvl;
    logic [7:0] led;
    logic       pump;
    logic       alarm;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  water_alarm_driver #(
    .TICK_DIV(4), .QUAL_TICKS(3), .SLOW_TICKS(4), .FAST_TICKS(1)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .ack(ack),
    .level_q(level_q), .led(led), .buzzer(buzzer), .pump(pump),
    .alarm_active(alarm_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Push the expected post-qualification outputs, drive the code, wait for acceptance
  task automatic step_to(input logic [2:0] v, input logic [7:0] l, input logic p, input logic a);
    exp_t e;
    int n;
    e.lvl = v; e.led = l; e.pump = p; e.alarm = a;
    sb.push_back(e);
    state = v;
    n = 0;
    while (level_q !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk_rng("qual_latency", n, 10, 13);
  endtask

  task automatic count_high(input int cycles, output int hi);
    hi = 0;
    repeat (cycles) begin
      if (buzzer === 1'b1) hi++;
      @(negedge clk);
    end
  endtask

  // Monitor: every accepted level change is matched one cycle later against the queue
  initial begin
    logic [2:0] last;
    exp_t e;
    last = 3'd0;
    forever begin
      @(negedge clk);
      if (rst) last = level_q;
      else if (level_q !== last) begin
        last = level_q;
        @(negedge clk);
        if (!rst) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got level %0d expected no change", level_q);
          end else begin
            e = sb.pop_front();
            chk("sb_level", level_q, e.lvl);
            chk("sb_led", led, e.led);
            chk("sb_pump", pump, e.pump);
            chk("sb_alarm", alarm_active, e.alarm);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, hi, lo;
    #3;
    chk("rst_led", led, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_pump", pump, 0);
    chk("rst_alarm", alarm_active, 0);
    chk("rst_level", level_q, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("led_first_edge", led, 8'h01);

    // Two-tick glitch to 110 must not be accepted
    state = 3'd6;
    repeat (8) @(negedge clk);
    state = 3'd0;
    repeat (20) @(negedge clk);
    chk("glitch_level", level_q, 0);
    chk("glitch_led", led, 8'h01);
    chk("glitch_buzzer", buzzer, 0);
    chk("glitch_pump", pump, 0);

    // Warning level: slow blink
    step_to(3'd5, 8'h3F, 1'b1, 1'b1);
    @(negedge clk);
    chk("alert_rise", buzzer, 1);
    n = 0;
    while (buzzer === 1'b1 && n < 40) begin n++; @(negedge clk); end
    chk_rng("slow_on_first", n, 13, 16);
    n = 0;
    while (buzzer === 1'b0 && n < 40) begin n++; @(negedge clk); end
    chk("slow_off", n, 16);
    n = 0;
    while (buzzer === 1'b1 && n < 40) begin n++; @(negedge clk); end
    chk("slow_on", n, 16);

    // Pump hysteresis walk down
    step_to(3'd4, 8'h1F, 1'b1, 1'b1);
    step_to(3'd3, 8'h0F, 1'b1, 1'b0);
    @(negedge clk);
    chk("normal_buzzer", buzzer, 0);
    step_to(3'd2, 8'h07, 1'b0, 1'b0);

    // 000 -> 011 never sets the pump
    step_to(3'd0, 8'h01, 1'b0, 1'b0);
    step_to(3'd3, 8'h0F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("walk_up_pump", pump, 0);

    // Alarm level: fast blink, then mute
    step_to(3'd6, 8'h7F, 1'b1, 1'b1);
    hi = 0; lo = 0;
    repeat (12) begin
      @(negedge clk);
      if (buzzer === 1'b1) hi++; else lo++;
    end
    chk("fast_has_on", int'(hi > 0), 1);
    chk("fast_has_off", int'(lo > 0), 1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("mute_buzzer", buzzer, 0);
    count_high(12, hi);
    chk("muted_quiet", hi, 0);

    // Lower level while muted stays silent; higher level re-alerts
    step_to(3'd5, 8'h3F, 1'b1, 1'b1);
    count_high(20, hi);
    chk("muted_lower", hi, 0);
    step_to(3'd7, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    count_high(20, hi);
    chk("lvl7_const", hi, 20);

    // Asynchronous reset mid-alarm
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_led", led, 0);
    chk("arst_buzzer", buzzer, 0);
    chk("arst_pump", pump, 0);
    chk("arst_alarm", alarm_active, 0);
    chk("arst_level", level_q, 0);
    repeat (2) @(negedge clk);
    begin
      exp_t e;
      e.lvl = 3'd7; e.led = 8'hFF; e.pump = 1'b1; e.alarm = 1'b1;
      sb.push_back(e);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("led_rearm", led, 8'h01);
    n = 1;
    while (level_q !== 3'd7 && n < 40) begin @(negedge clk); n++; end
    chk_rng("requal_latency", n, 10, 13);
    @(negedge clk);
    chk("post_rst_alert", buzzer, 1);

    // ack coincident with a drop below 4: drop wins
    step_to(3'd3, 8'h0F, 1'b1, 1'b0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("drop_ack_buzzer", buzzer, 0);
    count_high(8, hi);
    chk("drop_ack_quiet", hi, 0);
    step_to(3'd4, 8'h1F, 1'b1, 1'b1);
    @(negedge clk);
    chk("realert", buzzer, 1);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
